// File: rtl/cg_memory_slave.sv
// Memory-side endpoint of the CG handshake: single-outstanding read FSM plus single-cycle writes.
// Define CG_MEM_OOR_ERR_EN to flag out-of-range reads via rerr and drop out-of-range writes.
module cg_memory_slave #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata
`ifdef CG_MEM_OOR_ERR_EN
  ,
  output logic                  rerr
`endif
);

  localparam int unsigned OFF   = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      ar_idx, w_idx;
  logic                  ar_oor, w_oor;
  logic                  unused_addr;

  assign ar_idx = araddr[OFF+IDX_W-1:OFF];
  assign w_idx  = waddr[OFF+IDX_W-1:OFF];

`ifdef CG_MEM_OOR_ERR_EN
  logic rerr_q, rerr_d;

  assign ar_oor      = |araddr[ADDR_WIDTH-1:OFF+IDX_W];
  assign w_oor       = |waddr[ADDR_WIDTH-1:OFF+IDX_W];
  assign unused_addr = ^{araddr[OFF-1:0], waddr[OFF-1:0]};
  assign rerr        = rerr_q & rvalid;
`else
  // Upper address bits are ignored so accesses alias modulo DEPTH.
  assign ar_oor      = 1'b0;
  assign w_oor       = 1'b0;
  assign unused_addr = ^{araddr[OFF-1:0], waddr[OFF-1:0],
                         araddr[ADDR_WIDTH-1:OFF+IDX_W], waddr[ADDR_WIDTH-1:OFF+IDX_W]};
`endif

  assign arready = (state_q == StIdle) && !rst;
  assign rvalid  = (state_q == StResp);
  assign rdata   = data_q;
  assign wready  = !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef CG_MEM_OOR_ERR_EN
    rerr_d  = rerr_q;
`endif
    case (state_q)
      StIdle: begin
        if (arvalid) begin
          // Nonblocking array write on the same edge leaves this as the old word.
          data_d = ar_oor ? '0 : mem_q[ar_idx];
`ifdef CG_MEM_OOR_ERR_EN
          rerr_d = ar_oor;
`endif
          if (READ_LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CNT_W'(READ_LATENCY - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef CG_MEM_OOR_ERR_EN
      rerr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef CG_MEM_OOR_ERR_EN
      rerr_q  <= rerr_d;
`endif
    end
  end

  // Array has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wvalid && wready && wen && !w_oor) begin
      mem_q[w_idx] <= wdata;
    end
  end

endmodule
